// File: rtl/mycpu_exe_stage.sv
// EXE stage of the five-stage myCPU pipeline: ALU, 32-cycle shift-add multiplier,
// data SRAM request issue and forwarding/hazard export toward decode.
module mycpu_exe_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ds_to_es_valid,
   output logic        es_allowin,
   input  logic [31:0] ds_a,
   input  logic [31:0] ds_b,
   input  logic [3:0]  ds_aluop,
   input  logic [4:0]  ds_target_reg,
   input  logic        ds_reg_we,
   input  logic        ds_mem_re,
   input  logic        ds_mem_we,
   input  logic [31:0] ds_store_data,
   input  logic        ms_allowin,
   output logic        es_to_ms_valid,
   output logic [31:0] es_result,
   output logic [4:0]  es_target_reg,
   output logic        es_reg_we,
   output logic        es_mem_re,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_wen,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   output logic        es_fwd_we,
   output logic [4:0]  es_fwd_reg,
   output logic [31:0] es_fwd_data,
   output logic        es_fwd_ok
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  aluop;
      logic [4:0]  target_reg;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic [31:0] store_data;
   } es_ins_t;

   logic        es_valid_q, es_valid_d;
   es_ins_t     ins_q, ins_d;
   logic [1:0]  state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;

   logic        es_ready_go;
   logic        capture;
   logic        leave;
   logic [31:0] alu_res;

   assign es_ready_go    = !(es_valid_q && ins_q.aluop == OP_MUL && state_q != S_DONE);
   assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid_q && es_ready_go;
   assign capture        = ds_to_es_valid && es_allowin;
   assign leave          = es_to_ms_valid && ms_allowin;

   always_comb begin
      alu_res = ins_q.a;
      case (ins_q.aluop)
         4'd0:  alu_res = ins_q.a + ins_q.b;
         4'd1:  alu_res = ins_q.a - ins_q.b;
         4'd2:  alu_res = {31'b0, $signed(ins_q.a) < $signed(ins_q.b)};
         4'd3:  alu_res = {31'b0, ins_q.a < ins_q.b};
         4'd4:  alu_res = ins_q.a & ins_q.b;
         4'd5:  alu_res = ins_q.a | ins_q.b;
         4'd6:  alu_res = ins_q.a ^ ins_q.b;
         4'd7:  alu_res = ~(ins_q.a | ins_q.b);
         4'd8:  alu_res = ins_q.b << ins_q.a[4:0];
         4'd9:  alu_res = ins_q.b >> ins_q.a[4:0];
         4'd10: alu_res = $unsigned($signed(ins_q.b) >>> ins_q.a[4:0]);
         4'd11: alu_res = {ins_q.b[15:0], 16'b0};
         4'd12: alu_res = acc_q;
         default: alu_res = ins_q.a;
      endcase
   end

   assign es_result     = alu_res;
   assign es_target_reg = ins_q.target_reg;
   assign es_reg_we     = ins_q.reg_we;
   assign es_mem_re     = ins_q.mem_re;

   // SRAM request only in the advancing cycle, so read data lines up with MEM.
   assign data_sram_en    = es_valid_q && es_ready_go && ms_allowin && (ins_q.mem_re || ins_q.mem_we);
   assign data_sram_wen   = {4{ins_q.mem_we}} & {4{data_sram_en}};
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = ins_q.store_data;

   assign es_fwd_we   = es_valid_q && ins_q.reg_we && (ins_q.target_reg != 5'd0);
   assign es_fwd_reg  = ins_q.target_reg;
   assign es_fwd_data = alu_res;
   assign es_fwd_ok   = es_fwd_we && !ins_q.mem_re && es_ready_go;

   always_comb begin
      es_valid_d = es_valid_q;
      ins_d      = ins_q;
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      if (es_allowin) es_valid_d = ds_to_es_valid;
      if (capture) begin
         ins_d.a          = ds_a;
         ins_d.b          = ds_b;
         ins_d.aluop      = ds_aluop;
         ins_d.target_reg = ds_target_reg;
         ins_d.reg_we     = ds_reg_we;
         ins_d.mem_re     = ds_mem_re;
         ins_d.mem_we     = ds_mem_we;
         ins_d.store_data = ds_store_data;
      end
      case (state_q)
         S_RUN: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_DONE;
         end
         S_DONE: if (leave) state_d = S_IDLE;
         default: ;
      endcase
      // A MUL can only be captured from IDLE or from a departing DONE.
      if (capture && ds_aluop == OP_MUL) begin
         state_d  = S_RUN;
         mcand_d  = ds_a;
         mplier_d = ds_b;
         acc_d    = 32'd0;
         cnt_d    = 5'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         es_valid_q <= 1'b0;
         ins_q      <= '0;
         state_q    <= S_IDLE;
         mcand_q    <= 32'd0;
         mplier_q   <= 32'd0;
         acc_q      <= 32'd0;
         cnt_q      <= 5'd0;
      end else begin
         es_valid_q <= es_valid_d;
         ins_q      <= ins_d;
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mycpu_exe_stage.sv
// Bench for mycpu_exe_stage: directed cases plus randomized traffic scored
// against a cycle-level behavioural model of the stage.
module tb_mycpu_exe_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        d_valid;
   logic        es_allowin;
   logic [31:0] d_a, d_b, d_sd;
   logic [3:0]  d_op;
   logic [4:0]  d_tr;
   logic        d_we, d_re, d_wr;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [31:0] es_result;
   logic [4:0]  es_target_reg;
   logic        es_reg_we, es_mem_re;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        es_fwd_we;
   logic [4:0]  es_fwd_reg;
   logic [31:0] es_fwd_data;
   logic        es_fwd_ok;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 0;

   // model of the instruction held in EXE; m_age counts edges since capture
   bit          m_valid;
   logic [31:0] m_a, m_b, m_sd;
   logic [3:0]  m_op;
   logic [4:0]  m_tr;
   bit          m_we, m_re, m_wr;
   int          m_age;

   mycpu_exe_stage dut (
      .clk(clk), .resetn(resetn), .ds_to_es_valid(d_valid), .es_allowin(es_allowin),
      .ds_a(d_a), .ds_b(d_b), .ds_aluop(d_op), .ds_target_reg(d_tr), .ds_reg_we(d_we),
      .ds_mem_re(d_re), .ds_mem_we(d_wr), .ds_store_data(d_sd), .ms_allowin(ms_allowin),
      .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_target_reg(es_target_reg),
      .es_reg_we(es_reg_we), .es_mem_re(es_mem_re), .data_sram_en(data_sram_en),
      .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .es_fwd_we(es_fwd_we), .es_fwd_reg(es_fwd_reg),
      .es_fwd_data(es_fwd_data), .es_fwd_ok(es_fwd_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int sh;
      sh = int'(a % 32);
      p  = {32'd0, a} * {32'd0, b};
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:  return (a < b) ? 32'd1 : 32'd0;
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return a ^ b;
         4'd7:  return ~(a | b);
         4'd8:  return b << sh;
         4'd9:  return b >> sh;
         4'd10: return $unsigned($signed(b) >>> sh);
         4'd11: return b * 32'h10000;
         4'd12: return p[31:0];
         default: return a;
      endcase
   endfunction

   // compare all outputs against the model, then advance one clock and update the model
   task automatic cycle();
      bit rdy, en, fwe, alw;
      #4;
      rdy = !(m_valid && m_op == 4'd12 && m_age < 32);
      alw = !m_valid || (rdy && ms_allowin);
      en  = m_valid && rdy && ms_allowin && (m_re || m_wr);
      fwe = m_valid && m_we && (m_tr != 5'd0);
      if (chk_on) begin
         chk("allowin", 32'(es_allowin), 32'(alw));
         chk("to_ms_valid", 32'(es_to_ms_valid), 32'(m_valid && rdy));
         chk("sram_en", 32'(data_sram_en), 32'(en));
         chk("sram_wen", 32'(data_sram_wen), (en && m_wr) ? 32'hF : 32'h0);
         chk("fwd_we", 32'(es_fwd_we), 32'(fwe));
         if (fwe) begin
            chk("fwd_reg", 32'(es_fwd_reg), 32'(m_tr));
            chk("fwd_ok", 32'(es_fwd_ok), 32'(!m_re && rdy));
         end
         if (m_valid && rdy) begin
            chk("result", es_result, ref_alu(m_op, m_a, m_b));
            if (fwe) chk("fwd_data", es_fwd_data, ref_alu(m_op, m_a, m_b));
            if (en) begin
               chk("sram_addr", data_sram_addr, ref_alu(m_op, m_a, m_b));
               chk("sram_wdata", data_sram_wdata, m_sd);
            end
         end
      end
      @(posedge clk);
      if (!resetn) begin
         m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_op = 0; m_tr = 0;
         m_we = 0; m_re = 0; m_wr = 0; m_age = 0;
      end else if (alw) begin
         m_valid = d_valid;
         if (d_valid) begin
            m_a = d_a; m_b = d_b; m_sd = d_sd; m_op = d_op; m_tr = d_tr;
            m_we = d_we; m_re = d_re; m_wr = d_wr; m_age = 0;
         end
      end else begin
         m_age++;
      end
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tr, input bit we, input bit re, input bit wr,
                        input logic [31:0] sd);
      d_valid = 1; d_op = op; d_a = a; d_b = b; d_tr = tr;
      d_we = we; d_re = re; d_wr = wr; d_sd = sd;
   endtask

   task automatic mul_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
      int k;
      ms_allowin = 1; d_valid = 0;
      cycle();
      issue(4'd12, a, b, 5'd5, 1, 0, 0, 32'd0);
      cycle();
      d_valid = 0;
      k = 0;
      while (k < 40) begin
         #2;
         if (es_to_ms_valid) break;
         cycle();
         k++;
      end
      chk({tag, "_lat"}, 32'(k), 32'd32);
      chk({tag, "_res"}, es_result, exp);
      cycle();
   endtask

   initial begin
      resetn = 0; ms_allowin = 1;
      d_valid = 0; d_a = 0; d_b = 0; d_op = 0; d_tr = 0; d_we = 0; d_re = 0; d_wr = 0; d_sd = 0;
      m_valid = 0; m_age = 0;
      cycle(); cycle();
      resetn = 1; chk_on = 1;
      #2;
      chk("rst_allowin", 32'(es_allowin), 32'd1);
      chk("rst_to_ms", 32'(es_to_ms_valid), 32'd0);
      chk("rst_en", 32'(data_sram_en), 32'd0);
      chk("rst_wen", 32'(data_sram_wen), 32'd0);
      chk("rst_fwd_we", 32'(es_fwd_we), 32'd0);
      chk("rst_result", es_result, 32'd0);

      // back-to-back ALU ops
      issue(4'd0, 32'd5, 32'hFFFFFFFF, 5'd1, 1, 0, 0, 0);
      cycle(); #2; chk("add", es_result, 32'd4);
      issue(4'd10, 32'd4, 32'h80000000, 5'd2, 1, 0, 0, 0);
      cycle(); #2; chk("sra", es_result, 32'hF8000000);
      issue(4'd3, 32'd1, 32'hFFFFFFFF, 5'd3, 1, 0, 0, 0);
      cycle(); #2; chk("sltu", es_result, 32'd1);
      chk("b2b_valid", 32'(es_to_ms_valid), 32'd1);
      d_valid = 0;

      mul_test("mul7x6", 32'd7, 32'd6, 32'd42);
      mul_test("mulff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);

      // store held under backpressure
      d_valid = 0; cycle();
      issue(4'd0, 32'h100, 32'd8, 5'd0, 0, 0, 1, 32'hDEADBEEF);
      cycle();
      d_valid = 0; ms_allowin = 0;
      repeat (3) begin
         #2; chk("st_stall_en", 32'(data_sram_en), 32'd0);
         cycle();
      end
      ms_allowin = 1;
      #2;
      chk("st_en", 32'(data_sram_en), 32'd1);
      chk("st_wen", 32'(data_sram_wen), 32'hF);
      chk("st_addr", data_sram_addr, 32'h108);
      chk("st_wdata", data_sram_wdata, 32'hDEADBEEF);
      cycle();

      // load forwarding info, then a write to r0
      issue(4'd0, 32'h40, 32'd0, 5'd3, 1, 1, 0, 0);
      cycle();
      d_valid = 0; ms_allowin = 0;
      #2;
      chk("ld_fwd_we", 32'(es_fwd_we), 32'd1);
      chk("ld_fwd_reg", 32'(es_fwd_reg), 32'd3);
      chk("ld_fwd_ok", 32'(es_fwd_ok), 32'd0);
      ms_allowin = 1;
      issue(4'd5, 32'h1, 32'h2, 5'd0, 1, 0, 0, 0);
      cycle();
      d_valid = 0;
      #2; chk("r0_fwd_we", 32'(es_fwd_we), 32'd0);
      cycle();

      // reset in the middle of a multiply
      issue(4'd12, 32'd123, 32'd456, 5'd4, 1, 0, 0, 0);
      cycle();
      d_valid = 0;
      repeat (10) cycle();
      resetn = 0; cycle(); resetn = 1;
      #2;
      chk("rmul_to_ms", 32'(es_to_ms_valid), 32'd0);
      chk("rmul_allowin", 32'(es_allowin), 32'd1);
      mul_test("mul_after_rst", 32'h12345678, 32'd9, 32'hA3D70A38);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         d_valid    = ($urandom_range(0, 9) < 7);
         d_op       = ($urandom_range(0, 9) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
         d_a        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         d_b        = $urandom;
         d_tr       = 5'($urandom_range(0, 31));
         d_we       = 1'($urandom_range(0, 1));
         d_re       = ($urandom_range(0, 3) == 0);
         d_wr       = !d_re && ($urandom_range(0, 3) == 0);
         d_sd       = $urandom;
         ms_allowin = ($urandom_range(0, 3) != 0);
         resetn     = ($urandom_range(0, 199) != 0);
         cycle();
      end
      resetn = 1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
